// File: rtl/id_pkg.sv
//------------------------------------------------------------------
// id_pkg: shared ALU command encodings, default widths, NZCV bits.
// Revision: 1.0
//------------------------------------------------------------------
`default_nettype none

package id_pkg;

   localparam int DEF_DATA_W     = 32;
   localparam int DEF_REG_ADDR_W = 4;
   localparam int DEF_SHIFT_W    = 12;
   localparam int DEF_IMM_W      = 24;
   localparam int DEF_CNT_W      = 16;

   localparam int SR_N = 3;
   localparam int SR_Z = 2;
   localparam int SR_C = 1;
   localparam int SR_V = 0;

   typedef enum logic [3:0] {
      EXE_NOP = 4'b0000,
      EXE_MOV = 4'b0001,
      EXE_ADD = 4'b0010,
      EXE_ADC = 4'b0011,
      EXE_SUB = 4'b0100,
      EXE_SBC = 4'b0101,
      EXE_AND = 4'b0110,
      EXE_ORR = 4'b0111,
      EXE_EOR = 4'b1000,
      EXE_MVN = 4'b1001,
      EXE_CMP = 4'b1100,
      EXE_TST = 4'b1110
   } exe_cmd_e;

endpackage

`default_nettype wire

// File: rtl/id_exe_pipe_ctrl_if.sv
//------------------------------------------------------------------
// id_exe_pipe_ctrl_if: decoded ID-side fields in, registered EXE-side fields out.
// Revision: 1.0
//------------------------------------------------------------------
`default_nettype none

interface id_exe_pipe_ctrl_if
   import id_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int SHIFT_W    = DEF_SHIFT_W,
   parameter int IMM_W      = DEF_IMM_W
);
   logic                  in_valid;
   logic                  wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
   logic [3:0]            exe_cmd_in;
   logic [3:0]            sr_in;
   logic [DATA_W-1:0]     pc_in, val_rn_in, val_rm_in;
   logic [SHIFT_W-1:0]    shift_operand_in;
   logic [IMM_W-1:0]      signed_imm_in;
   logic [REG_ADDR_W-1:0] dest_in;
   logic [REG_ADDR_W-1:0] src1, src2;
   logic                  src1_used, two_src;

   logic                  out_valid;
   logic                  wb_en, mem_r_en, mem_w_en, b, s, imm;
   logic [3:0]            exe_cmd;
   logic [3:0]            sr;
   logic [DATA_W-1:0]     pc, val_rn, val_rm;
   logic [SHIFT_W-1:0]    shift_operand;
   logic [IMM_W-1:0]      signed_imm;
   logic [REG_ADDR_W-1:0] dest;

   modport master (
      output in_valid, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in,
             exe_cmd_in, sr_in, pc_in, val_rn_in, val_rm_in, shift_operand_in,
             signed_imm_in, dest_in, src1, src2, src1_used, two_src,
      input  out_valid, wb_en, mem_r_en, mem_w_en, b, s, imm, exe_cmd, sr, pc,
             val_rn, val_rm, shift_operand, signed_imm, dest
   );

   modport slave (
      input  in_valid, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in,
             exe_cmd_in, sr_in, pc_in, val_rn_in, val_rm_in, shift_operand_in,
             signed_imm_in, dest_in, src1, src2, src1_used, two_src,
      output out_valid, wb_en, mem_r_en, mem_w_en, b, s, imm, exe_cmd, sr, pc,
             val_rn, val_rm, shift_operand, signed_imm, dest
   );

endinterface

`default_nettype wire

// File: rtl/id_hazard_unit.sv
//------------------------------------------------------------------
// id_hazard_unit: RAW detection of the ID instruction against EXE/MEM destinations.
// Revision: 1.0
//------------------------------------------------------------------
`default_nettype none

module id_hazard_unit
   import id_pkg::*;
#(
   parameter int REG_ADDR_W = DEF_REG_ADDR_W,
   parameter bit FORWARD_EN = 1'b0
) (
   input  wire logic                  in_valid,
   input  wire logic [REG_ADDR_W-1:0] src1,
   input  wire logic [REG_ADDR_W-1:0] src2,
   input  wire logic                  src1_used,
   input  wire logic                  two_src,
   input  wire logic [REG_ADDR_W-1:0] exe_dest,
   input  wire logic [REG_ADDR_W-1:0] mem_dest,
   input  wire logic                  exe_wb_en,
   input  wire logic                  exe_mem_r_en,
   input  wire logic                  mem_wb_en,
   output logic                       raw
);

   logic match_exe, match_mem;
   logic raw_stall_all, raw_load_use;

   // A register read on both sources collapses into a single match.
   assign match_exe = in_valid & ((src1_used & (src1 == exe_dest)) |
                                  (two_src   & (src2 == exe_dest)));
   assign match_mem = in_valid & ((src1_used & (src1 == mem_dest)) |
                                  (two_src   & (src2 == mem_dest)));

   assign raw_stall_all = (match_exe & exe_wb_en) | (match_mem & mem_wb_en);
   assign raw_load_use  = match_exe & exe_mem_r_en;

   assign raw = FORWARD_EN ? raw_load_use : raw_stall_all;

endmodule

`default_nettype wire

// File: rtl/id_exe_pipe_ctrl.sv
//------------------------------------------------------------------
// id_exe_pipe_ctrl: ID->EXE pipeline register with hazard bubbles, flush, freeze, perf counters.
// Revision: 1.0
//------------------------------------------------------------------
`default_nettype none

module id_exe_pipe_ctrl
   import id_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int SHIFT_W    = DEF_SHIFT_W,
   parameter int IMM_W      = DEF_IMM_W,
   parameter bit FORWARD_EN = 1'b0,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  wire logic                  clk,
   input  wire logic                  rst,
   input  wire logic                  freeze,
   input  wire logic                  flush,
   input  wire logic [REG_ADDR_W-1:0] exe_dest,
   input  wire logic [REG_ADDR_W-1:0] mem_dest,
   input  wire logic                  exe_wb_en,
   input  wire logic                  exe_mem_r_en,
   input  wire logic                  mem_wb_en,
   output logic                       hazard,
   output logic [CNT_W-1:0]           stall_cnt,
   output logic [CNT_W-1:0]           flush_cnt,
   id_exe_pipe_ctrl_if.slave          bus
);

   localparam int FIELD_W = 6 + 4 + 4 + 3*DATA_W + SHIFT_W + IMM_W + REG_ADDR_W;

   logic               raw;
   logic [FIELD_W-1:0] load_vec;
   logic [FIELD_W-1:0] fields_d, fields_q;
   logic               valid_d, valid_q;
   logic [CNT_W-1:0]   stall_cnt_d, stall_cnt_q;
   logic [CNT_W-1:0]   flush_cnt_d, flush_cnt_q;

   id_hazard_unit #(
      .REG_ADDR_W (REG_ADDR_W),
      .FORWARD_EN (FORWARD_EN)
   ) u_hazard (
      .in_valid     (bus.in_valid),
      .src1         (bus.src1),
      .src2         (bus.src2),
      .src1_used    (bus.src1_used),
      .two_src      (bus.two_src),
      .exe_dest     (exe_dest),
      .mem_dest     (mem_dest),
      .exe_wb_en    (exe_wb_en),
      .exe_mem_r_en (exe_mem_r_en),
      .mem_wb_en    (mem_wb_en),
      .raw          (raw)
   );

   // A wrong-path instruction must never hold IF.
   assign hazard = raw & ~flush;

   assign load_vec = {bus.wb_en_in, bus.mem_r_en_in, bus.mem_w_en_in, bus.b_in,
                      bus.s_in, bus.imm_in, bus.exe_cmd_in, bus.sr_in,
                      bus.pc_in, bus.val_rn_in, bus.val_rm_in,
                      bus.shift_operand_in, bus.signed_imm_in, bus.dest_in};

   always_comb begin
      fields_d    = fields_q;
      valid_d     = valid_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;

      if (flush) begin
         fields_d = '0;
         valid_d  = 1'b0;
      end else if (freeze) begin
         fields_d = fields_q;
         valid_d  = valid_q;
      end else if (hazard || !bus.in_valid) begin
         fields_d = '0;
         valid_d  = 1'b0;
      end else begin
         fields_d = load_vec;
         valid_d  = 1'b1;
      end

      if (hazard && !freeze && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush && (flush_cnt_q != '1))
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fields_q    <= '0;
         valid_q     <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         fields_q    <= fields_d;
         valid_q     <= valid_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign {bus.wb_en, bus.mem_r_en, bus.mem_w_en, bus.b, bus.s, bus.imm,
           bus.exe_cmd, bus.sr, bus.pc, bus.val_rn, bus.val_rm,
           bus.shift_operand, bus.signed_imm, bus.dest} = fields_q;

   assign bus.out_valid = valid_q;
   assign stall_cnt     = stall_cnt_q;
   assign flush_cnt     = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_id_exe_pipe_ctrl.sv
//------------------------------------------------------------------
// tb_id_exe_pipe_ctrl: directed bench; u0 stalls on any RAW, u1 forwards with a 2-bit counter.
// Revision: 1.0
//------------------------------------------------------------------
`default_nettype none

module tb_id_exe_pipe_ctrl;
   import id_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        freeze, flush, in_valid;
   logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
   logic [3:0]  exe_cmd_in, sr_in, dest_in, src1, src2, exe_dest, mem_dest;
   logic [31:0] pc_in, val_rn_in, val_rm_in;
   logic [11:0] shift_in;
   logic [23:0] simm_in;
   logic        src1_used, two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;

   logic        hazard0, hazard1;
   logic [15:0] stall0, flush0;
   logic [1:0]  stall1, flush1;

   int n_tests = 0;
   int n_fail  = 0;

   id_exe_pipe_ctrl_if if0 ();
   id_exe_pipe_ctrl_if if1 ();

   assign if0.in_valid = in_valid;         assign if1.in_valid = in_valid;
   assign if0.wb_en_in = wb_en_in;         assign if1.wb_en_in = wb_en_in;
   assign if0.mem_r_en_in = mem_r_en_in;   assign if1.mem_r_en_in = mem_r_en_in;
   assign if0.mem_w_en_in = mem_w_en_in;   assign if1.mem_w_en_in = mem_w_en_in;
   assign if0.b_in = b_in;                 assign if1.b_in = b_in;
   assign if0.s_in = s_in;                 assign if1.s_in = s_in;
   assign if0.imm_in = imm_in;             assign if1.imm_in = imm_in;
   assign if0.exe_cmd_in = exe_cmd_in;     assign if1.exe_cmd_in = exe_cmd_in;
   assign if0.sr_in = sr_in;               assign if1.sr_in = sr_in;
   assign if0.pc_in = pc_in;               assign if1.pc_in = pc_in;
   assign if0.val_rn_in = val_rn_in;       assign if1.val_rn_in = val_rn_in;
   assign if0.val_rm_in = val_rm_in;       assign if1.val_rm_in = val_rm_in;
   assign if0.shift_operand_in = shift_in; assign if1.shift_operand_in = shift_in;
   assign if0.signed_imm_in = simm_in;     assign if1.signed_imm_in = simm_in;
   assign if0.dest_in = dest_in;           assign if1.dest_in = dest_in;
   assign if0.src1 = src1;                 assign if1.src1 = src1;
   assign if0.src2 = src2;                 assign if1.src2 = src2;
   assign if0.src1_used = src1_used;       assign if1.src1_used = src1_used;
   assign if0.two_src = two_src;           assign if1.two_src = two_src;

   id_exe_pipe_ctrl #(.FORWARD_EN(1'b0), .CNT_W(16)) u0 (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .exe_dest(exe_dest), .mem_dest(mem_dest), .exe_wb_en(exe_wb_en),
      .exe_mem_r_en(exe_mem_r_en), .mem_wb_en(mem_wb_en),
      .hazard(hazard0), .stall_cnt(stall0), .flush_cnt(flush0), .bus(if0)
   );

   id_exe_pipe_ctrl #(.FORWARD_EN(1'b1), .CNT_W(2)) u1 (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .exe_dest(exe_dest), .mem_dest(mem_dest), .exe_wb_en(exe_wb_en),
      .exe_mem_r_en(exe_mem_r_en), .mem_wb_en(mem_wb_en),
      .hazard(hazard1), .stall_cnt(stall1), .flush_cnt(flush1), .bus(if1)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      freeze = 0; flush = 0; in_valid = 0;
      wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; b_in = 0; s_in = 0; imm_in = 0;
      exe_cmd_in = 0; sr_in = 0; dest_in = 0; src1 = 0; src2 = 0;
      exe_dest = 0; mem_dest = 0; pc_in = 0; val_rn_in = 0; val_rm_in = 0;
      shift_in = 0; simm_in = 0; src1_used = 0; two_src = 0;
      exe_wb_en = 0; exe_mem_r_en = 0; mem_wb_en = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1;
      step();
      step();
      n_tests++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", if0.out_valid); end
      n_tests++; if (if0.pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", if0.pc); end
      n_tests++; if (stall0 !== 16'd0) begin n_fail++; $display("FAIL reset_stall: got %0d expected 0", stall0); end
      n_tests++; if (flush0 !== 16'd0) begin n_fail++; $display("FAIL reset_flush: got %0d expected 0", flush0); end
      rst = 0;
   endtask

   task automatic test_load();
      clear_inputs();
      in_valid = 1; wb_en_in = 1; mem_w_en_in = 1; s_in = 1; imm_in = 1;
      exe_cmd_in = EXE_MVN; sr_in = 4'hA; dest_in = 4'd5;
      pc_in = 32'h0000_0100; val_rn_in = 32'hDEAD_BEEF; val_rm_in = 32'h1234_5678;
      shift_in = 12'hABC; simm_in = 24'hFFF123;
      step();
      n_tests++; if (if0.out_valid !== 1'b1) begin n_fail++; $display("FAIL load_valid: got %b expected 1", if0.out_valid); end
      n_tests++; if ({if0.wb_en, if0.mem_r_en, if0.mem_w_en, if0.b, if0.s, if0.imm} !== 6'b101011)
         begin n_fail++; $display("FAIL load_ctrl: got %b expected 101011", {if0.wb_en, if0.mem_r_en, if0.mem_w_en, if0.b, if0.s, if0.imm}); end
      n_tests++; if ({if0.exe_cmd, if0.sr, if0.dest} !== 12'h9A5) begin n_fail++; $display("FAIL load_cmd_sr_dest: got %h expected 9a5", {if0.exe_cmd, if0.sr, if0.dest}); end
      n_tests++; if ({if0.pc, if0.val_rn, if0.val_rm} !== 96'h0000_0100_DEAD_BEEF_1234_5678)
         begin n_fail++; $display("FAIL load_data: got %h expected 00000100deadbeef12345678", {if0.pc, if0.val_rn, if0.val_rm}); end
      n_tests++; if ({if0.shift_operand, if0.signed_imm} !== 36'hABC_FFF123) begin n_fail++; $display("FAIL load_shift_imm: got %h expected abcfff123", {if0.shift_operand, if0.signed_imm}); end
      in_valid = 0;
      step();
      n_tests++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b expected 0", if0.out_valid); end
      n_tests++; if ({if0.pc, if0.val_rn, if0.dest, if0.wb_en} !== 69'h0) begin n_fail++; $display("FAIL idle_zeroed: got %h expected 0", {if0.pc, if0.val_rn, if0.dest, if0.wb_en}); end
   endtask

   task automatic test_saturation();
      logic [1:0] exp_seq [5];
      exp_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      clear_inputs();
      in_valid = 1; src1 = 4'd3; src1_used = 1; exe_dest = 4'd3; exe_mem_r_en = 1;
      #1;
      n_tests++; if (hazard1 !== 1'b1) begin n_fail++; $display("FAIL sat_hazard1: got %b expected 1", hazard1); end
      n_tests++; if (hazard0 !== 1'b0) begin n_fail++; $display("FAIL sat_hazard0_no_wb: got %b expected 0", hazard0); end
      for (int i = 0; i < 5; i++) begin
         step();
         n_tests++; if (stall1 !== exp_seq[i]) begin n_fail++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, stall1, exp_seq[i]); end
      end
      n_tests++; if (if1.out_valid !== 1'b0) begin n_fail++; $display("FAIL sat_bubble: got %b expected 0", if1.out_valid); end
      n_tests++; if (stall0 !== 16'd0) begin n_fail++; $display("FAIL sat_stall0: got %0d expected 0", stall0); end
   endtask

   task automatic test_raw_nofwd();
      clear_inputs();
      in_valid = 1; pc_in = 32'h10; src1 = 4'd3; src1_used = 1; exe_dest = 4'd3; exe_wb_en = 1;
      #1;
      n_tests++; if (hazard0 !== 1'b1) begin n_fail++; $display("FAIL raw_exe_hazard0: got %b expected 1", hazard0); end
      n_tests++; if (hazard1 !== 1'b0) begin n_fail++; $display("FAIL raw_exe_hazard1: got %b expected 0", hazard1); end
      step();
      n_tests++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL raw_bubble: got %b expected 0", if0.out_valid); end
      n_tests++; if (stall0 !== 16'd1) begin n_fail++; $display("FAIL raw_stall0: got %0d expected 1", stall0); end
      n_tests++; if (if1.out_valid !== 1'b1) begin n_fail++; $display("FAIL raw_fwd_load: got %b expected 1", if1.out_valid); end
      exe_wb_en = 0; src1_used = 0; two_src = 1; src2 = 4'd7; mem_dest = 4'd7; mem_wb_en = 1;
      #1;
      n_tests++; if (hazard0 !== 1'b1) begin n_fail++; $display("FAIL raw_mem_hazard0: got %b expected 1", hazard0); end
      n_tests++; if (hazard1 !== 1'b0) begin n_fail++; $display("FAIL raw_mem_hazard1: got %b expected 0", hazard1); end
      mem_wb_en = 0;
      #1;
      n_tests++; if (hazard0 !== 1'b0) begin n_fail++; $display("FAIL raw_mem_nowb: got %b expected 0", hazard0); end
      exe_dest = 4'd0; src1 = 4'd0; src2 = 4'd0; src1_used = 1; two_src = 1; exe_wb_en = 1;
      #1;
      n_tests++; if (hazard0 !== 1'b1) begin n_fail++; $display("FAIL raw_r0_hazard: got %b expected 1", hazard0); end
      step();
      n_tests++; if (stall0 !== 16'd2) begin n_fail++; $display("FAIL raw_dual_once: got %0d expected 2", stall0); end
      in_valid = 0;
      #1;
      n_tests++; if (hazard0 !== 1'b0) begin n_fail++; $display("FAIL raw_invalid: got %b expected 0", hazard0); end
   endtask

   task automatic test_forwarding();
      clear_inputs();
      in_valid = 1; src1 = 4'd3; src1_used = 1; exe_dest = 4'd3;
      #1;
      n_tests++; if (hazard1 !== 1'b0) begin n_fail++; $display("FAIL fwd_noload: got %b expected 0", hazard1); end
      mem_dest = 4'd3; mem_wb_en = 1;
      #1;
      n_tests++; if (hazard1 !== 1'b0) begin n_fail++; $display("FAIL fwd_mem_ignored: got %b expected 0", hazard1); end
      n_tests++; if (hazard0 !== 1'b1) begin n_fail++; $display("FAIL nofwd_mem: got %b expected 1", hazard0); end
      mem_wb_en = 0; exe_mem_r_en = 1;
      #1;
      n_tests++; if (hazard1 !== 1'b1) begin n_fail++; $display("FAIL fwd_loaduse: got %b expected 1", hazard1); end
      step();
      n_tests++; if (if1.out_valid !== 1'b0) begin n_fail++; $display("FAIL fwd_bubble: got %b expected 0", if1.out_valid); end
      n_tests++; if (stall1 !== 2'd3) begin n_fail++; $display("FAIL fwd_sat_hold: got %0d expected 3", stall1); end
      exe_mem_r_en = 0; pc_in = 32'h200;
      #1;
      n_tests++; if (hazard1 !== 1'b0) begin n_fail++; $display("FAIL fwd_release: got %b expected 0", hazard1); end
      step();
      n_tests++; if (if1.out_valid !== 1'b1 || if1.pc !== 32'h200) begin n_fail++; $display("FAIL fwd_reload: got valid=%b pc=%h expected 1/00000200", if1.out_valid, if1.pc); end
   endtask

   task automatic test_flush();
      clear_inputs();
      in_valid = 1; pc_in = 32'h300;
      step();
      n_tests++; if (if0.out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre: got %b expected 1", if0.out_valid); end
      src1 = 4'd3; src1_used = 1; exe_dest = 4'd3; exe_wb_en = 1; freeze = 1; flush = 1;
      #1;
      n_tests++; if (hazard0 !== 1'b0) begin n_fail++; $display("FAIL flush_hazard_mask: got %b expected 0", hazard0); end
      step();
      n_tests++; if (if0.out_valid !== 1'b0 || if0.pc !== 32'h0) begin n_fail++; $display("FAIL flush_bubble: got valid=%b pc=%h expected 0/0", if0.out_valid, if0.pc); end
      n_tests++; if (flush0 !== 16'd1) begin n_fail++; $display("FAIL flush_cnt: got %0d expected 1", flush0); end
      n_tests++; if (stall0 !== 16'd2) begin n_fail++; $display("FAIL flush_stall_hold: got %0d expected 2", stall0); end
      n_tests++; if (flush1 !== 2'd1) begin n_fail++; $display("FAIL flush_cnt1: got %0d expected 1", flush1); end
   endtask

   task automatic test_freeze();
      clear_inputs();
      in_valid = 1; pc_in = 32'h40;
      step();
      n_tests++; if (if0.pc !== 32'h40) begin n_fail++; $display("FAIL freeze_load: got %h expected 00000040", if0.pc); end
      freeze = 1; pc_in = 32'h80; src1 = 4'd3; src1_used = 1; exe_dest = 4'd3; exe_wb_en = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_tests++; if (if0.pc !== 32'h40 || if0.out_valid !== 1'b1) begin n_fail++; $display("FAIL freeze_hold[%0d]: got pc=%h valid=%b expected 00000040/1", i, if0.pc, if0.out_valid); end
         n_tests++; if (stall0 !== 16'd2 || flush0 !== 16'd1) begin n_fail++; $display("FAIL freeze_cnt[%0d]: got %0d/%0d expected 2/1", i, stall0, flush0); end
      end
   endtask

   task automatic test_reset_mid_stall();
      clear_inputs();
      in_valid = 1; pc_in = 32'h33;
      step();
      n_tests++; if (if0.pc !== 32'h33) begin n_fail++; $display("FAIL rst_pre_load: got %h expected 00000033", if0.pc); end
      src1 = 4'd3; src1_used = 1; exe_dest = 4'd3; exe_wb_en = 1;
      #1;
      rst = 1;
      #1;
      n_tests++; if (if0.out_valid !== 1'b0 || if0.pc !== 32'h0) begin n_fail++; $display("FAIL rst_async_out: got valid=%b pc=%h expected 0/0", if0.out_valid, if0.pc); end
      n_tests++; if (stall0 !== 16'd0 || flush0 !== 16'd0 || stall1 !== 2'd0 || flush1 !== 2'd0)
         begin n_fail++; $display("FAIL rst_async_cnt: got %0d/%0d/%0d/%0d expected 0", stall0, flush0, stall1, flush1); end
      rst = 0;
      #1;
      n_tests++; if (hazard0 !== 1'b1) begin n_fail++; $display("FAIL rst_hazard_recompute: got %b expected 1", hazard0); end
      exe_wb_en = 0; pc_in = 32'h55;
      step();
      n_tests++; if (if0.out_valid !== 1'b1 || if0.pc !== 32'h55) begin n_fail++; $display("FAIL rst_clean_load: got valid=%b pc=%h expected 1/00000055", if0.out_valid, if0.pc); end
      n_tests++; if (stall0 !== 16'd0) begin n_fail++; $display("FAIL rst_stall_post: got %0d expected 0", stall0); end
   endtask

   initial begin
      test_reset();
      test_load();
      test_saturation();
      test_raw_nofwd();
      test_forwarding();
      test_flush();
      test_freeze();
      test_reset_mid_stall();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
